// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: shared constants for the GPIO interrupt peripheral.
// Holds the CSR register map, the bank-select field position and the
// legal parameter ranges used by gpio_irq and its sub-modules.
package gpio_irq_pkg;

  // Position of the bank-select field within the 14-bit CSR address
  localparam int BANK_SEL_MSB = 13;
  localparam int BANK_SEL_LSB = 10;

  // Legal parameter ranges
  localparam int WIDTH_MIN       = 1;
  localparam int WIDTH_MAX       = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 3;

  // Register index type (csr_a[3:0])
  typedef logic [3:0] reg_idx_t;

  // Register map
  localparam reg_idx_t GPIO_IN      = 4'd0;
  localparam reg_idx_t GPIO_OUT     = 4'd1;
  localparam reg_idx_t GPIO_OE      = 4'd2;
  localparam reg_idx_t GPIO_SET     = 4'd3;
  localparam reg_idx_t GPIO_CLR     = 4'd4;
  localparam reg_idx_t GPIO_RISE_EN = 4'd5;
  localparam reg_idx_t GPIO_FALL_EN = 4'd6;
  localparam reg_idx_t GPIO_PENDING = 4'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: vectored multi-flop input synchroniser followed by a
// one-cycle delay register, producing per-channel rise/fall strobes.
module gpio_sync_edge
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  // Shift raw pins through the synchroniser chain and keep last cycle's s
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq: CSR-mapped GPIO block with tri-state outputs, synchronised
// inputs and per-channel edge interrupts latched in a W1C pending register.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter logic [3:0]  csr_addr    = 4'h1,
  parameter int          WIDTH       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] INIT_OUT    = 32'h0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [13:0]      csr_a,
  input  logic             csr_we,
  input  logic [31:0]      csr_di,
  output logic [31:0]      csr_do,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic             sel;
  logic             wr_en;
  reg_idx_t         reg_idx;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pend_set;
  logic [WIDTH-1:0] pend_clr;
  logic [31:0]      rd_data;
  logic             unused_csr;

  assign sel     = (csr_a[BANK_SEL_MSB:BANK_SEL_LSB] == csr_addr);
  assign reg_idx = csr_a[3:0];
  assign wr_en   = csr_we & sel;
  assign wr_data = csr_di[WIDTH-1:0];

  // Address bits [9:4] are undecoded; data bits above WIDTH are discarded
  assign unused_csr = ^{csr_a[9:4], csr_di};

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .d       (gpio_in),
    .s       (s),
    .rise    (rise),
    .fall    (fall)
  );

  assign pend_set = (rise & rise_en_q) | (fall & fall_en_q);
  assign pend_clr = (wr_en && (reg_idx == GPIO_PENDING)) ? wr_data : '0;

  // Read mux: write-only and undecoded indices return zero
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      GPIO_IN:      rd_data[WIDTH-1:0] = s;
      GPIO_OUT:     rd_data[WIDTH-1:0] = out_q;
      GPIO_OE:      rd_data[WIDTH-1:0] = oe_q;
      GPIO_RISE_EN: rd_data[WIDTH-1:0] = rise_en_q;
      GPIO_FALL_EN: rd_data[WIDTH-1:0] = fall_en_q;
      GPIO_PENDING: rd_data[WIDTH-1:0] = pending_q;
      default:      rd_data = '0;
    endcase
  end

  // Software-writable configuration registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      out_q     <= INIT_OUT[WIDTH-1:0];
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        GPIO_OUT:     out_q     <= wr_data;
        GPIO_OE:      oe_q      <= wr_data;
        GPIO_SET:     out_q     <= out_q | wr_data;
        GPIO_CLR:     out_q     <= out_q & ~wr_data;
        GPIO_RISE_EN: rise_en_q <= wr_data;
        GPIO_FALL_EN: fall_en_q <= wr_data;
        default:      ;
      endcase
    end
  end

  // Pending latch (new events win over a same-cycle clear) and level irq
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pending_q <= '0;
      irq       <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~pend_clr) | pend_set;
      irq       <= |pending_q;
    end
  end

  // Registered read data, zero when another bank is addressed
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      csr_do <= '0;
    end else begin
      csr_do <= sel ? rd_data : '0;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;

endmodule

// File: doc/gpio_irq.md
# gpio_irq

Parametrised successor to the CSR GPIO peripheral. Provides up to 32 channels of output with tri-state enable, synchronised input sampling, and per-channel rising/falling edge detection. Edge events latch into a write-1-to-clear pending register that drives a level interrupt to the CPU. It sits on the CSR bus behind `csrbrg`, and its read data is OR-combined with the other CSR slaves.

## Interface
- `csr_addr`, default 4'h1: CSR bank select; the block responds when `csr_a[13:10] == csr_addr`.
- `WIDTH`, default 32: channel count, legal range 1..32.
- `SYNC_STAGES`, default 2: input synchroniser depth, legal range 2..3.
- `INIT_OUT`, default 32'h0: reset value of OUT; only bits [WIDTH-1:0] are used.
- `sys_clk`  in  1: system clock; all state is on the rising edge.
- `sys_rst`  in  1: reset, asynchronous and active-high.
- `csr_a`  in  14: CSR address.
- `csr_we`  in  1: CSR write strobe.
- `csr_di`  in  32: CSR write data.
- `csr_do`  out  32: CSR read data; registered, and zero when the block is not selected.
- `gpio_in`  in  WIDTH: asynchronous pin inputs.
- `gpio_out`  out  WIDTH: output values, driven directly from OUT.
- `gpio_oe`  out  WIDTH: per-pin output enables, driven directly from OE.
- `irq`  out  1: level interrupt; registered OR-reduction of PENDING.

## Operation
- **Select:** `sel = (csr_a[13:10] == csr_addr)`. Register index is `csr_a[3:0]`.
- **Undecoded space:** `csr_a[9:4]` is ignored. Indices 8..15 read 0 and ignore writes.
- **Register map:**
  - 0 IN (RO): synchronised inputs.
  - 1 OUT (RW).
  - 2 OE (RW).
  - 3 OUT_SET (WO): `OUT |= di`; reads 0.
  - 4 OUT_CLR (WO): `OUT &= ~di`; reads 0.
  - 5 RISE_EN (RW).
  - 6 FALL_EN (RW).
  - 7 PENDING: reads pending bits; writing 1 to a bit clears it.
- **Width rule:** bits [31:WIDTH] of every register read 0, and writes to those bits are discarded.
- **Synchroniser:** `gpio_in` passes through SYNC_STAGES flops to give `s`; `prev` holds `s` delayed by one cycle.
- **Edge detect:** `rise = s & ~prev` and `fall = ~s & prev`.
- **Pending set:** `set = (rise & RISE_EN) | (fall & FALL_EN)`.
- **Pending update:** `PENDING <= (PENDING & ~clr) | set`, where `clr = di` when PENDING is written, else 0. Set wins over a simultaneous clear of the same bit.
- **Enable is not retroactive:** enabling an edge while the input is already at the post-edge level does not set pending.
- **Disable keeps pending:** clearing RISE_EN or FALL_EN does not clear pending bits already latched.
- **Interrupt:** `irq <= |PENDING`. The block has no global mask; the CPU masks via its IM register.
- **Reset values:**
  - OUT = INIT_OUT[WIDTH-1:0].
  - OE, RISE_EN, FALL_EN, PENDING = 0.
  - Synchroniser flops and `prev` = 0.
  - `csr_do` = 0 and `irq` = 0.
- **Reset mid-operation:** all state returns to its reset value immediately. A pin held high through reset release produces a rise event after SYNC_STAGES+1 cycles, but since RISE_EN = 0 no pending bit is set.

## Timing
- **CSR read:** address presented in cycle N; `csr_do` is valid after edge N+1 and held for one cycle. Reads have no side effects.
- **CSR write:** takes effect at the edge that samples `csr_we`. `gpio_out`/`gpio_oe` change on that same edge. A read of the same register in the following cycle returns the new value.
- **Input-to-interrupt latency:** take E0 as the first edge that samples the new `gpio_in` level.
  - `s` updates at E(SYNC_STAGES-1).
  - PENDING bit sets at E(SYNC_STAGES).
  - `irq` asserts at E(SYNC_STAGES+1).
- **IN register:** reflects `s`; a read issued in the cycle after E(SYNC_STAGES-1) returns the new level.
- **Clear latency:** a PENDING write at edge W clears the bit at W; `irq` deasserts at W+1 if no other bits remain set.
- **Minimum pulse width:** an input pulse must last at least one full `sys_clk` period to be detected. A pulse that returns before `prev` updates produces a rise and a fall on consecutive cycles, setting both kinds of event if both are enabled.

## Structure
- **Shared package `gpio_irq_pkg`:**
  - Register index constants: GPIO_IN, GPIO_OUT, GPIO_OE, GPIO_SET, GPIO_CLR, GPIO_RISE_EN, GPIO_FALL_EN, GPIO_PENDING.
  - The bank-select field position, [13:10].
  - The legal ranges of WIDTH and SYNC_STAGES.
- **Sub-module `gpio_sync_edge`:** a vectored synchroniser plus `prev` register. Parameters WIDTH and SYNC_STAGES. Outputs `s`, `rise`, `fall`.
- **Top level:** the CSR decode and register file stay in the top module.

## Test plan
- **Reset values:** with INIT_OUT = 32'hA5, assert `sys_rst` asynchronously mid-cycle.
  - `gpio_out` = 8'hA5 immediately; `gpio_oe` = 0, `irq` = 0, `csr_do` = 0.
  - Reading OUT returns 32'h000000A5 (WIDTH = 8).
- **Set/clear writes:** write OUT = 32'hF0, then OUT_SET 32'h0F, then OUT_CLR 32'h81.
  - `gpio_out` sequence: F0, FF, 7E.
  - OUT_SET/OUT_CLR reads return 0; writes to bits above WIDTH read back 0.
- **Rising-edge interrupt:** RISE_EN = 32'h1, SYNC_STAGES = 2; drive `gpio_in[0]` 0→1 before E0.
  - PENDING = 1 at E2; `irq` = 1 at E3.
  - Writing PENDING = 1 at E5 gives `irq` = 0 at E6.
- **Set wins over clear:** with FALL_EN[3] = 1, place a falling edge on `gpio_in[3]` timed so that `set[3]` occurs in the same cycle as a PENDING write of 32'h8.
  - PENDING[3] remains 1 and `irq` stays high.
- **Bank select and undecoded space:**
  - `csr_a` = {csr_addr + 1, 10'h1} with `csr_we` = 1: no register changes, `csr_do` = 0.
  - Index 4'hB read returns 0.
- **Short pulse with both edges enabled:** 1-cycle high pulse on `gpio_in[1]` with RISE_EN = FALL_EN = 32'h2.
  - PENDING[1] is set; a single PENDING write of 32'h2 clears it.
  - Enabling RISE_EN while the pin is already high leaves PENDING = 0.
